// File: rtl/y_index_sequencer.sv
// Y index register sequencer: accepts one micro-op per handshake, drives the
// Y load/inc/dec strobes, computes N/Z/C and forms Y-indexed effective addresses.
module y_index_sequencer #(
    parameter bit         ALWAYS_FIX = 1'b0,
    parameter logic [7:0] ZP_PAGE    = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [7:0]  op_data,
    input  logic [7:0]  base_hi,
    input  logic [7:0]  y_value,
    output logic        y_load,
    output logic [7:0]  y_load_data,
    output logic        y_increment,
    output logic        y_decrement,
    output logic [15:0] ea_out,
    output logic        ea_valid,
    output logic        page_cross,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flags_valid,
    output logic        op_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_LOAD    = 3'd1;
    localparam logic [2:0] OP_INC     = 3'd2;
    localparam logic [2:0] OP_DEC     = 3'd3;
    localparam logic [2:0] OP_CMP     = 3'd4;
    localparam logic [2:0] OP_IDX_ABS = 3'd5;
    localparam logic [2:0] OP_IDX_ZP  = 3'd6;

    logic [1:0]  state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  ysnap_q, ysnap_d;
    logic        fix_q, fix_d;

    logic        y_load_q, y_load_d;
    logic [7:0]  y_load_data_q, y_load_data_d;
    logic        y_inc_q, y_inc_d;
    logic        y_dec_q, y_dec_d;
    logic [15:0] ea_q, ea_d;
    logic        ea_valid_q, ea_valid_d;
    logic        page_cross_q, page_cross_d;
    logic        n_q, n_d;
    logic        z_q, z_d;
    logic        c_q, c_d;
    logic        flags_valid_q, flags_valid_d;
    logic        done_q, done_d;

    logic        accept;
    logic [8:0]  live_sum;
    logic [8:0]  snap_sum;
    logic [7:0]  inc_r;
    logic [7:0]  dec_r;
    logic [7:0]  cmp_r;
    logic        take_fix;

    assign op_ready = (state_q == ST_IDLE);
    assign accept   = op_valid && op_ready;

    // EXEC-cycle results come from the live inputs so they can be registered
    // on the accept edge; FIX-cycle results come from the captured snapshot.
    assign live_sum = {1'b0, op_data} + {1'b0, y_value};
    assign snap_sum = {1'b0, data_q} + {1'b0, ysnap_q};
    assign inc_r    = y_value + 8'd1;
    assign dec_r    = y_value - 8'd1;
    assign cmp_r    = y_value - op_data;
    assign take_fix = live_sum[8] || ALWAYS_FIX;

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        hi_d          = hi_q;
        ysnap_d       = ysnap_q;
        fix_d         = fix_q;
        y_load_d      = 1'b0;
        y_load_data_d = 8'h00;
        y_inc_d       = 1'b0;
        y_dec_d       = 1'b0;
        ea_d          = 16'h0000;
        ea_valid_d    = 1'b0;
        page_cross_d  = 1'b0;
        n_d           = 1'b0;
        z_d           = 1'b0;
        c_d           = 1'b0;
        flags_valid_d = 1'b0;
        done_d        = 1'b0;

        unique case (1'b1)
            (state_q == ST_IDLE): begin
                if (accept) begin
                    state_d = ST_EXEC;
                    data_d  = op_data;
                    hi_d    = base_hi;
                    ysnap_d = y_value;
                    fix_d   = 1'b0;
                    done_d  = 1'b1;
                    case (op_code)
                        OP_LOAD: begin
                            y_load_d      = 1'b1;
                            y_load_data_d = op_data;
                            flags_valid_d = 1'b1;
                            n_d           = op_data[7];
                            z_d           = (op_data == 8'h00);
                        end
                        OP_INC: begin
                            y_inc_d       = 1'b1;
                            flags_valid_d = 1'b1;
                            n_d           = inc_r[7];
                            z_d           = (inc_r == 8'h00);
                        end
                        OP_DEC: begin
                            y_dec_d       = 1'b1;
                            flags_valid_d = 1'b1;
                            n_d           = dec_r[7];
                            z_d           = (dec_r == 8'h00);
                        end
                        OP_CMP: begin
                            flags_valid_d = 1'b1;
                            n_d           = cmp_r[7];
                            z_d           = (y_value == op_data);
                            c_d           = (y_value >= op_data);
                        end
                        OP_IDX_ABS: begin
                            ea_valid_d   = 1'b1;
                            ea_d         = {base_hi, live_sum[7:0]};
                            page_cross_d = live_sum[8];
                            fix_d        = take_fix;
                            done_d       = !take_fix;
                        end
                        OP_IDX_ZP: begin
                            ea_valid_d = 1'b1;
                            ea_d       = {ZP_PAGE, live_sum[7:0]};
                        end
                        OP_NOP: begin
                            done_d = 1'b1;
                        end
                        default: begin
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            (state_q == ST_EXEC): begin
                fix_d = 1'b0;
                if (fix_q) begin
                    // Corrected high byte; FFxx + carry wraps to 00xx.
                    state_d      = ST_FIX;
                    ea_valid_d   = 1'b1;
                    ea_d         = {hi_q + {7'd0, snap_sum[8]}, snap_sum[7:0]};
                    page_cross_d = page_cross_q;
                    done_d       = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fix_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            data_q        <= 8'h00;
            hi_q          <= 8'h00;
            ysnap_q       <= 8'h00;
            fix_q         <= 1'b0;
            y_load_q      <= 1'b0;
            y_load_data_q <= 8'h00;
            y_inc_q       <= 1'b0;
            y_dec_q       <= 1'b0;
            ea_q          <= 16'h0000;
            ea_valid_q    <= 1'b0;
            page_cross_q  <= 1'b0;
            n_q           <= 1'b0;
            z_q           <= 1'b0;
            c_q           <= 1'b0;
            flags_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            hi_q          <= hi_d;
            ysnap_q       <= ysnap_d;
            fix_q         <= fix_d;
            y_load_q      <= y_load_d;
            y_load_data_q <= y_load_data_d;
            y_inc_q       <= y_inc_d;
            y_dec_q       <= y_dec_d;
            ea_q          <= ea_d;
            ea_valid_q    <= ea_valid_d;
            page_cross_q  <= page_cross_d;
            n_q           <= n_d;
            z_q           <= z_d;
            c_q           <= c_d;
            flags_valid_q <= flags_valid_d;
            done_q        <= done_d;
        end
    end

    assign y_load      = y_load_q;
    assign y_load_data = y_load_data_q;
    assign y_increment = y_inc_q;
    assign y_decrement = y_dec_q;
    assign ea_out      = ea_q;
    assign ea_valid    = ea_valid_q;
    assign page_cross  = page_cross_q;
    assign flag_n      = n_q;
    assign flag_z      = z_q;
    assign flag_c      = c_q;
    assign flags_valid = flags_valid_q;
    assign op_done     = done_q;

endmodule

// File: tb/tb_y_index_sequencer.sv
// Directed bench for y_index_sequencer: vector table plus reset and
// back-to-back handshake sequences, on ALWAYS_FIX=0 and ALWAYS_FIX=1 copies.
module tb_y_index_sequencer;

    typedef struct {
        logic [2:0]  code;
        logic [7:0]  data;
        logic [7:0]  hi;
        logic [7:0]  yv;
        logic        af;
        logic [2:0]  strb;
        logic [7:0]  ld;
        logic [3:0]  flg;
        logic        eav;
        logic [15:0] ea;
        logic        pc;
        logic        done;
        logic        fix;
        logic [15:0] fea;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic op_valid = 1'b0;
    logic [2:0] op_code = 3'd0;
    logic [7:0] op_data = 8'h00;
    logic [7:0] base_hi = 8'h00;
    logic [7:0] y_value = 8'h00;
    logic sel = 1'b0;

    logic        r0, ld0, inc0, dec0, eav0, pc0, n0, z0, c0, fv0, dn0;
    logic [7:0]  ldd0;
    logic [15:0] ea0;
    logic        r1, ld1, inc1, dec1, eav1, pc1, n1, z1, c1, fv1, dn1;
    logic [7:0]  ldd1;
    logic [15:0] ea1;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    y_index_sequencer #(.ALWAYS_FIX(1'b0), .ZP_PAGE(8'h00)) dut0 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(r0),
        .op_code(op_code), .op_data(op_data), .base_hi(base_hi),
        .y_value(y_value), .y_load(ld0), .y_load_data(ldd0),
        .y_increment(inc0), .y_decrement(dec0), .ea_out(ea0),
        .ea_valid(eav0), .page_cross(pc0), .flag_n(n0), .flag_z(z0),
        .flag_c(c0), .flags_valid(fv0), .op_done(dn0)
    );

    y_index_sequencer #(.ALWAYS_FIX(1'b1), .ZP_PAGE(8'h00)) dut1 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(r1),
        .op_code(op_code), .op_data(op_data), .base_hi(base_hi),
        .y_value(y_value), .y_load(ld1), .y_load_data(ldd1),
        .y_increment(inc1), .y_decrement(dec1), .ea_out(ea1),
        .ea_valid(eav1), .page_cross(pc1), .flag_n(n1), .flag_z(z1),
        .flag_c(c1), .flags_valid(fv1), .op_done(dn1)
    );

    wire        s_rdy  = sel ? r1 : r0;
    wire [2:0]  s_strb = sel ? {ld1, inc1, dec1} : {ld0, inc0, dec0};
    wire [7:0]  s_ld   = sel ? ldd1 : ldd0;
    wire [3:0]  s_flg  = sel ? {fv1, n1, z1, c1} : {fv0, n0, z0, c0};
    wire        s_eav  = sel ? eav1 : eav0;
    wire [15:0] s_ea   = sel ? ea1 : ea0;
    wire        s_pc   = sel ? pc1 : pc0;
    wire        s_dn   = sel ? dn1 : dn0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            passed++;
    endtask

    function automatic vec_t mk(
        input logic [2:0] code, input logic [7:0] data, input logic [7:0] hi,
        input logic [7:0] yv, input logic af, input logic [2:0] strb,
        input logic [7:0] ld, input logic [3:0] flg, input logic eav,
        input logic [15:0] ea, input logic pc, input logic done,
        input logic fix, input logic [15:0] fea);
        vec_t v;
        v.code = code; v.data = data; v.hi = hi; v.yv = yv; v.af = af;
        v.strb = strb; v.ld = ld; v.flg = flg; v.eav = eav; v.ea = ea;
        v.pc = pc; v.done = done; v.fix = fix; v.fea = fea;
        return v;
    endfunction

    vec_t vecs[14];

    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        sel      = v.af;
        op_valid = 1'b1;
        op_code  = v.code;
        op_data  = v.data;
        base_hi  = v.hi;
        y_value  = v.yv;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_data  = ~v.data;
        base_hi  = ~v.hi;
        y_value  = ~v.yv;
        @(negedge clk);
        chk({t, " exec ready"}, {15'd0, s_rdy}, 16'd0);
        chk({t, " exec strobes"}, {13'd0, s_strb}, {13'd0, v.strb});
        chk({t, " exec load_data"}, {8'd0, s_ld}, {8'd0, v.ld});
        chk({t, " exec flags"}, {12'd0, s_flg}, {12'd0, v.flg});
        chk({t, " exec ea_valid"}, {15'd0, s_eav}, {15'd0, v.eav});
        chk({t, " exec ea"}, s_ea, v.ea);
        chk({t, " exec page_cross"}, {15'd0, s_pc}, {15'd0, v.pc});
        chk({t, " exec done"}, {15'd0, s_dn}, {15'd0, v.done});
        @(negedge clk);
        if (v.fix) begin
            chk({t, " fix ready"}, {15'd0, s_rdy}, 16'd0);
            chk({t, " fix strobes"}, {13'd0, s_strb}, 16'd0);
            chk({t, " fix flags"}, {12'd0, s_flg}, 16'd0);
            chk({t, " fix ea_valid"}, {15'd0, s_eav}, 16'd1);
            chk({t, " fix ea"}, s_ea, v.fea);
            chk({t, " fix page_cross"}, {15'd0, s_pc}, {15'd0, v.pc});
            chk({t, " fix done"}, {15'd0, s_dn}, 16'd1);
            @(negedge clk);
        end
        chk({t, " idle ready"}, {15'd0, s_rdy}, 16'd1);
        chk({t, " idle strobes"}, {13'd0, s_strb}, 16'd0);
        chk({t, " idle ea_valid"}, {15'd0, s_eav}, 16'd0);
        chk({t, " idle ea"}, s_ea, 16'd0);
        chk({t, " idle flags"}, {12'd0, s_flg}, 16'd0);
        chk({t, " idle done"}, {15'd0, s_dn}, 16'd0);
    endtask

    initial begin
        int rdy_cnt;
        int ld_cnt;
        int dn_cnt;

        //           code  data   hi     yv     af  strb  ld     flg   eav ea        pc done fix fea
        vecs[0]  = mk(3'd1, 8'h80, 8'h00, 8'h00, 0, 3'b100, 8'h80, 4'hC, 0, 16'h0000, 0, 1, 0, 16'h0000);
        vecs[1]  = mk(3'd1, 8'h00, 8'h00, 8'h55, 0, 3'b100, 8'h00, 4'hA, 0, 16'h0000, 0, 1, 0, 16'h0000);
        vecs[2]  = mk(3'd2, 8'h00, 8'h00, 8'hFF, 0, 3'b010, 8'h00, 4'hA, 0, 16'h0000, 0, 1, 0, 16'h0000);
        vecs[3]  = mk(3'd3, 8'h00, 8'h00, 8'h00, 0, 3'b001, 8'h00, 4'hC, 0, 16'h0000, 0, 1, 0, 16'h0000);
        vecs[4]  = mk(3'd4, 8'h10, 8'h00, 8'h10, 0, 3'b000, 8'h00, 4'hB, 0, 16'h0000, 0, 1, 0, 16'h0000);
        vecs[5]  = mk(3'd4, 8'h11, 8'h00, 8'h10, 0, 3'b000, 8'h00, 4'hC, 0, 16'h0000, 0, 1, 0, 16'h0000);
        vecs[6]  = mk(3'd5, 8'hF0, 8'h12, 8'h20, 0, 3'b000, 8'h00, 4'h0, 1, 16'h1210, 1, 0, 1, 16'h1310);
        vecs[7]  = mk(3'd5, 8'h10, 8'h12, 8'h20, 0, 3'b000, 8'h00, 4'h0, 1, 16'h1230, 0, 1, 0, 16'h0000);
        vecs[8]  = mk(3'd5, 8'h10, 8'h12, 8'h20, 1, 3'b000, 8'h00, 4'h0, 1, 16'h1230, 0, 0, 1, 16'h1230);
        vecs[9]  = mk(3'd6, 8'hF0, 8'h12, 8'h20, 0, 3'b000, 8'h00, 4'h0, 1, 16'h0010, 0, 1, 0, 16'h0000);
        vecs[10] = mk(3'd5, 8'hF0, 8'hFF, 8'h20, 0, 3'b000, 8'h00, 4'h0, 1, 16'hFF10, 1, 0, 1, 16'h0010);
        vecs[11] = mk(3'd0, 8'h12, 8'h34, 8'h56, 0, 3'b000, 8'h00, 4'h0, 0, 16'h0000, 0, 1, 0, 16'h0000);
        vecs[12] = mk(3'd7, 8'h12, 8'h34, 8'h56, 0, 3'b000, 8'h00, 4'h0, 0, 16'h0000, 0, 1, 0, 16'h0000);
        vecs[13] = mk(3'd2, 8'h00, 8'h00, 8'h7F, 0, 3'b010, 8'h00, 4'hC, 0, 16'h0000, 0, 1, 0, 16'h0000);

        #12;
        chk("reset ready", {15'd0, r0}, 16'd1);
        chk("reset strobes", {13'd0, ld0, inc0, dec0}, 16'd0);
        chk("reset load_data", {8'd0, ldd0}, 16'd0);
        chk("reset ea", ea0, 16'd0);
        chk("reset flags", {11'd0, fv0, n0, z0, c0, pc0}, 16'd0);
        chk("reset valid/done", {14'd0, eav0, dn0}, 16'd0);
        chk("reset af1 ready", {15'd0, r1}, 16'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            run_vec(i, vecs[i]);

        // Reset asserted during EXEC of an INC.
        sel = 1'b0;
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = 3'd2;
        y_value  = 8'h05;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        chk("rst_mid inc before", {15'd0, inc0}, 16'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid inc dropped", {15'd0, inc0}, 16'd0);
        chk("rst_mid ready", {15'd0, r0}, 16'd1);
        chk("rst_mid done", {15'd0, dn0}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid after done", {15'd0, dn0}, 16'd0);
        chk("rst_mid after inc", {15'd0, inc0}, 16'd0);

        // op_valid held high: acceptance only every second cycle.
        rdy_cnt = 0;
        ld_cnt  = 0;
        dn_cnt  = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = 3'd1;
        op_data  = 8'h33;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rdy_cnt += int'(r0);
            ld_cnt  += int'(ld0);
            dn_cnt  += int'(dn0);
            if (ld0 && r0)
                chk("hold load while ready", 16'd1, 16'd0);
        end
        op_valid = 1'b0;
        chk("hold ready count", rdy_cnt[15:0], 16'd5);
        chk("hold load count", ld_cnt[15:0], 16'd5);
        chk("hold done count", dn_cnt[15:0], 16'd5);
        repeat (2) @(negedge clk);
        chk("hold end ready", {15'd0, r0}, 16'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/y_index_sequencer.md
Name: y_index_sequencer

Overview:
- Controller for the Y index register: accepts one micro-op per handshake from instruction decode and sequences the register's load, increment and decrement strobes.
- Computes N/Z/C flags for the op.
- Generates Y-indexed effective addresses (absolute,Y and zero-page,Y), including the extra page-fix cycle on carry.
- Sits between the decode/timing logic and the Y index register; the register's present value is fed back in on y_value.

Parameters:
- ALWAYS_FIX, 0: 1 = absolute,Y always spends the FIX cycle (store timing); 0 = only on page crossing.
- ZP_PAGE, 8'h00: high byte driven on ea_out for zero-page,Y.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  micro-op offered
- op_ready  out  1  sequencer can accept an op
- op_code  in  3  0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 CMP, 5 IDX_ABS, 6 IDX_ZP, 7 reserved
- op_data  in  8  load/compare operand, or base address low byte
- base_hi  in  8  base address high byte (IDX_ABS)
- y_value  in  8  current Y register contents
- y_load  out  1  Y register load strobe
- y_load_data  out  8  value to load
- y_increment  out  1  Y increment strobe
- y_decrement  out  1  Y decrement strobe
- ea_out  out  16  effective address
- ea_valid  out  1  ea_out valid this cycle
- page_cross  out  1  IDX_ABS low-byte add carried
- flag_n, flag_z, flag_c  out  1 each  result flags
- flags_valid  out  1  flags valid this cycle
- op_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; op_ready=1; every other output 0, including ea_out and y_load_data.
- Reset mid-op: abandons the op and drops any strobe immediately; no op_done.
- Handshake: an op is accepted on a clk edge with op_valid && op_ready.
  - op_ready=1 only in IDLE, so there is no back-to-back acceptance.
  - At accept, op_code, op_data, base_hi and y_value are captured as y_snap.
  - Later changes to the inputs are ignored until the next accept.
- States: IDLE -> EXEC on accept. EXEC -> FIX if op is IDX_ABS and (carry or ALWAYS_FIX); otherwise EXEC -> IDLE. FIX -> IDLE.
- Strobes:
  - Asserted only in EXEC, for exactly one cycle.
  - At most one of y_load, y_increment, y_decrement is high in any cycle.
  - The Y register is level-sensitive, so strobe width must never exceed one cycle.
- LOAD: y_load=1, y_load_data=op_data. Flags from op_data: N=bit7, Z=(op_data==0). flag_c=0 and is don't-care.
- INC: y_increment=1. r=y_snap+1 mod 256; N=r[7], Z=(r==0). Wrap FF->00 gives Z=1.
- DEC: y_decrement=1. r=y_snap-1 mod 256; N=r[7], Z=(r==0). Wrap 00->FF gives N=1.
- CMP: no strobe. r=y_snap-op_data mod 256; C=(y_snap>=op_data) unsigned, Z=(y_snap==op_data), N=r[7].
- IDX_ABS: {carry,lo}=op_data+y_snap (9-bit).
  - EXEC: ea_out={base_hi,lo}, ea_valid=1, page_cross=carry.
  - If FIX is taken: ea_valid=1 again in FIX with ea_out={base_hi+carry mod 256, lo}; page_cross held. Wrap FFxx+carry gives 00xx.
  - EXEC-cycle ea (uncorrected high byte) is the dummy-read address.
- IDX_ZP: ea_out={ZP_PAGE,(op_data+y_snap) mod 256}, ea_valid=1 in EXEC. Wraps within the page; page_cross=0.
- flags_valid: asserted in EXEC for LOAD/INC/DEC/CMP; 0 for IDX and NOP.
- NOP and reserved code 7: EXEC with no strobes, no flags, no ea.
- op_done: asserted in the final cycle of every op (EXEC, or FIX when taken).
- Latency: 2 cycles accept-to-accept; 3 when FIX is taken.
- Outside the qualifying cycle, ea_out, flag and strobe outputs return to 0 (registered outputs).

Test Plan:
- Reset asserted mid-EXEC of INC -> y_increment drops the same cycle, op_ready=1, no op_done.
- LOAD op_data=8'h80 -> one cycle y_load=1, y_load_data=80, N=1, Z=0, op_done; then LOAD 00 -> Z=1, N=0.
- INC with y_value=FF -> y_increment for exactly 1 cycle, Z=1, N=0. DEC with y_value=00 -> N=1, Z=0.
- CMP y_value=10, op_data=10 -> C=1, Z=1, N=0. Then op_data=11 -> C=0, Z=0, N=1.
- IDX_ABS base_hi=12, op_data=F0, y_value=20:
  - EXEC: ea=1210, page_cross=1.
  - FIX: ea=1310, op_done in FIX.
  - Repeat with op_data=10 -> ea=1230, no FIX; with ALWAYS_FIX=1 -> FIX present, ea=1230 both cycles.
- IDX_ZP op_data=F0, y_value=20 -> ea=0010, page_cross=0. Hold op_valid high continuously -> an accept every 2nd cycle only; y_value changes after accept do not alter results.
